aes_basys3_ctrl: RTL and testbench

Board-level control and display sequencer between the Basys3 push-buttons/LEDs and the sequential AES encryption core. It debounces the start and page buttons and issues a single-cycle start pulse to the core. It tracks the core's busy/done handshake with a timeout, captures the full ciphertext on completion, and pages through it on the LEDs one LED_W-bit window at a time.

---
 rtl/aes_basys3_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes_basys3_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_basys3_ctrl.sv
// -----------------------------------------------------------------------------
// aes_basys3_ctrl
//   Board-level sequencer between the Basys3 buttons/LEDs and a sequential AES
//   core. It debounces the start and page buttons and fires a one-cycle
//   core_start pulse. It then waits for core_done, with a timeout. On
//   completion it captures the ciphertext and pages through it on the LEDs,
//   LED_W bits at a time.
//
// Optional feature (macro AES_CYCLE_COUNT_EN):
//   A 16-bit saturating WAIT-latency counter, shown on an extra page NPAGES.
//
// Ports:
//   clk              100 MHz system clock
//   rst_n            asynchronous active-low reset
//   btn_start        raw start button (asynchronous)
//   btn_next         raw page-advance button (asynchronous)
//   core_done        done level from the AES core
//   core_ciphertext  ciphertext bus from the AES core (DATA_W)
//   core_start       one-cycle start pulse to the AES core
//   led              registered ciphertext window (LED_W)
//   page             index of the window currently shown (PG_W)
//   busy             high while in START or WAIT
//   err              core did not finish within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module aes_basys3_ctrl #(
  parameter int unsigned DATA_W          = 128,
  parameter int unsigned LED_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned PG_W            = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_next,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_ciphertext,
  output logic              core_start,
  output logic [LED_W-1:0]  led,
  output logic [PG_W-1:0]   page,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NPAGES = DATA_W / LED_W;
`ifdef AES_CYCLE_COUNT_EN
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(NPAGES);
`else
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(NPAGES - 1);
`endif
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SHOW  = 2'd3;

  // ---------------------------------------------------------------------------
  // Button path. Bit 0 is start and bit 1 is next.
  // ---------------------------------------------------------------------------
  logic [1:0]           w_btn_raw;
  logic [1:0]           r_sync1;
  logic [1:0]           r_sync2;
  logic [1:0]           r_deb;
  logic [1:0]           r_deb_q;
  logic [1:0][DB_W-1:0] r_dbcnt;
  logic                 w_start_p;
  logic                 w_next_p;

  assign w_btn_raw = {btn_next, btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_dbcnt <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int unsigned i = 0; i < 2; i++) begin
        // The count only runs while the synchronised level disagrees with the
        // accepted level. Any agreeing cycle restarts the count, so bounces
        // shorter than DEBOUNCE_CYCLES are discarded.
        if (r_sync2[i] == r_deb[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i]   <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_start_p = r_deb[0] & ~r_deb_q[0];
  assign w_next_p  = r_deb[1] & ~r_deb_q[1];

  // ---------------------------------------------------------------------------
  // Control FSM, capture register and page index
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [TO_W-1:0]   r_tcnt;
  logic              r_err;
  logic [PG_W-1:0]   r_page;
  logic [DATA_W-1:0] r_cap;
  logic [LED_W-1:0]  r_led;
  logic [LED_W-1:0]  w_window;
`ifdef AES_CYCLE_COUNT_EN
  logic [15:0]       r_lat;
`endif

  always_comb begin
    w_window = '0;
    for (int unsigned i = 0; i < NPAGES; i++) begin
      if (r_page == PG_W'(i)) w_window = r_cap[i*LED_W +: LED_W];
    end
`ifdef AES_CYCLE_COUNT_EN
    if (r_page == PG_W'(NPAGES)) w_window = LED_W'(r_lat);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_page  <= '0;
      r_cap   <= '0;
      r_led   <= '0;
`ifdef AES_CYCLE_COUNT_EN
      r_lat   <= '0;
`endif
    end else begin
      r_led <= w_window;
      case (r_state)
        S_IDLE: begin
          if (w_start_p) r_state <= S_START;
        end
        S_START: begin
          r_err   <= 1'b0;
          r_tcnt  <= '0;
`ifdef AES_CYCLE_COUNT_EN
          r_lat   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
`ifdef AES_CYCLE_COUNT_EN
          if (r_lat != '1) r_lat <= r_lat + 1'b1;
`endif
          // done takes priority over the timeout in the final WAIT cycle
          if (core_done) begin
            r_cap   <= core_ciphertext;
            r_page  <= '0;
            r_state <= S_SHOW;
          end else if (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_SHOW;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (w_start_p) begin
            r_state <= S_START;
          end else if (w_next_p) begin
            r_page <= (r_page == PG_LAST) ? '0 : r_page + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start = (r_state == S_START);
  assign busy       = (r_state == S_START) || (r_state == S_WAIT);
  assign err        = r_err;
  assign page       = r_page;
  assign led        = r_led;

endmodule

// File: tb/tb_aes_basys3_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_basys3_ctrl
//   Scoreboard bench for aes_basys3_ctrl with short debounce and timeout
//   values. The stimulus updates an abstract model of the board: capture
//   value, page, mode and latency. From it the stimulus pushes the expected
//   events. A monitor pops an event each time the DUT shows a start pulse, a
//   run completion or a page change, and compares it.
// -----------------------------------------------------------------------------
module tb_aes_basys3_ctrl;

  localparam int DATA_W = 128;
  localparam int LED_W  = 16;
  localparam int DB     = 4;
  localparam int TO     = 64;
  localparam int PG_W   = 4;
  localparam int NPAGES = DATA_W / LED_W;
`ifdef AES_CYCLE_COUNT_EN
  localparam int NPG = NPAGES + 1;
`else
  localparam int NPG = NPAGES;
`endif

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_PAGE  = 2;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_SHOW = 2;

  logic              clk;
  logic              rst_n;
  logic              btn_start;
  logic              btn_next;
  logic              core_done;
  logic [DATA_W-1:0] core_ciphertext;
  logic              core_start;
  logic [LED_W-1:0]  led;
  logic [PG_W-1:0]   page;
  logic              busy;
  logic              err;

  aes_basys3_ctrl #(
    .DATA_W(DATA_W),
    .LED_W(LED_W),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES(TO),
    .PG_W(PG_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start(btn_start),
    .btn_next(btn_next),
    .core_done(core_done),
    .core_ciphertext(core_ciphertext),
    .core_start(core_start),
    .led(led),
    .page(page),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    longint      cyc;
    logic        err;
    int          blen;
    logic [3:0]  page;
    logic [15:0] led;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // behavioural model of the board
  logic [127:0] m_cap  = '0;
  int           m_page = 0;
  int           m_lat  = 0;
  int           m_mode = M_IDLE;
  int           tb_delay = 12;       // WAIT delay of the core; -1 = never done
  logic [127:0] tb_ct  = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_led();
    if (m_page == NPAGES) return 16'(m_lat);
    return 16'(m_cap >> (m_page * 16));
  endfunction

  task automatic pop(input int kind, output exp_t e, output bit ok);
    n_cmp++;
    ok = 1'b0;
    e = '{kind: -1, cyc: 0, err: 1'b0, blen: 0, page: '0, led: '0};
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        n_bad++;
        $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // AES core model: drop done on start, then raise it with the result later
  initial begin
    core_done       = 1'b0;
    core_ciphertext = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        core_done       = 1'b0;
        core_ciphertext = {$urandom, $urandom, $urandom, $urandom};
        if (tb_delay >= 0) begin
          repeat (tb_delay) @(posedge clk);
          #1;
          core_done       = 1'b1;
          core_ciphertext = tb_ct;
        end
      end
    end
  end

  // monitor
  initial begin
    bit   prev_busy;
    int   prev_page;
    int   blen;
    exp_t e;
    bit   ok;
    prev_busy = 1'b0;
    prev_page = 0;
    blen      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        prev_page = 0;
        blen      = 0;
      end else begin
        if (core_start) begin
          pop(K_START, e, ok);
          if (ok) chk("start_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (busy) blen++;
        if (prev_busy && !busy) begin
          pop(K_DONE, e, ok);
          if (ok) begin
            chk("busy_len", 64'(blen), 64'(e.blen));
            chk("err", 64'(err), 64'(e.err));
          end
          @(negedge clk);
          if (ok) begin
            chk("done_page", 64'(page), 64'(e.page));
            chk("done_led", 64'(led), 64'(e.led));
          end
          blen      = 0;
          prev_page = int'(page);
        end else if (int'(page) != prev_page) begin
          pop(K_PAGE, e, ok);
          @(negedge clk);
          if (ok) begin
            chk("page", 64'(page), 64'(e.page));
            chk("page_led", 64'(led), 64'(e.led));
          end
          prev_page = int'(page);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input bit st, input bit nx, input bit lvl);
    if (st) btn_start = lvl;
    if (nx) btn_next = lvl;
  endtask

  task automatic model_press(input bit st, input bit nx, input longint rise, input bit no_done);
    exp_t e;
    int   waitc;
    if (st && m_mode != M_BUSY) begin
      e = '{kind: K_START, cyc: rise + 2 + DB + 1, err: 1'b0, blen: 0, page: '0, led: '0};
      q.push_back(e);
      m_mode = M_BUSY;
      if (!no_done) begin
        if (tb_delay >= 0) begin
          waitc  = (tb_delay == 0) ? 1 : tb_delay;
          m_cap  = tb_ct;
          m_page = 0;
        end else begin
          waitc = TO;
        end
        m_lat = (waitc > 65535) ? 65535 : waitc;
        e = '{kind: K_DONE, cyc: 0, err: (tb_delay < 0), blen: 1 + waitc,
              page: 4'(m_page), led: m_led()};
        q.push_back(e);
      end
    end else if (nx && !st && m_mode == M_SHOW) begin
      m_page = (m_page + 1) % NPG;
      e = '{kind: K_PAGE, cyc: 0, err: 1'b0, blen: 0, page: 4'(m_page), led: m_led()};
      q.push_back(e);
    end
  endtask

  task automatic press(input bit st, input bit nx, input int bounces, input bit no_done);
    longint rise;
    for (int b = 0; b < bounces; b++) begin
      set_btn(st, nx, 1'b1);
      repeat (2) tick();
      set_btn(st, nx, 1'b0);
      repeat (2) tick();
    end
    set_btn(st, nx, 1'b1);
    rise = cyc;
    model_press(st, nx, rise, no_done);
    repeat ($urandom_range(DB + 10, DB + 2)) tick();
    set_btn(st, nx, 1'b0);
    repeat (2 + DB + 3) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < 2000), 64'd1);
    m_mode = M_SHOW;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_next  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // next is ignored in IDLE
    press(1'b0, 1'b1, 0, 1'b0);

    // NIST run, with a bouncing start button
    tb_ct    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tb_delay = 12;
    press(1'b1, 1'b0, 3, 1'b0);
    wait_idle();

    // walk every page, including the wrap back to 0
    for (int i = 0; i < NPG; i++) press(1'b0, 1'b1, $urandom_range(2, 0), 1'b0);

    // next and start are both ignored while WAIT is running
    tb_delay = 45;
    tb_ct    = {$urandom, $urandom, $urandom, $urandom};
    press(1'b1, 1'b0, 0, 1'b0);
    press(1'b0, 1'b1, 0, 1'b0);
    press(1'b1, 1'b0, 0, 1'b0);
    wait_idle();

    // timeout keeps the capture and the page
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 0, 1'b0);
    tb_delay = -1;
    press(1'b1, 1'b0, 0, 1'b0);
    wait_idle();

    // simultaneous start and next: start wins and the page is unchanged
    press(1'b1, 1'b1, 0, 1'b0);
    wait_idle();

    // randomized runs and paging
    for (int r = 0; r < 8; r++) begin
      tb_delay = int'($urandom_range(60, 0));
      tb_ct    = {$urandom, $urandom, $urandom, $urandom};
      press(1'b1, 1'b0, $urandom_range(3, 0), 1'b0);
      wait_idle();
      repeat ($urandom_range(10, 0)) press(1'b0, 1'b1, $urandom_range(2, 0), 1'b0);
    end

    // reset in the middle of WAIT
    tb_delay = -1;
    press(1'b1, 1'b0, 0, 1'b1);
    chk("busy_midwait", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_core_start", 64'(core_start), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_page", 64'(page), 64'd0);
    chk("mrst_led", 64'(led), 64'd0);
    repeat (3) tick();
    rst_n  = 1'b1;
    m_mode = M_IDLE;
    m_cap  = '0;
    m_page = 0;
    m_lat  = 0;
    repeat (20) tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    press(1'b0, 1'b1, 0, 1'b0);
    chk("post_rst_page", 64'(page), 64'd0);

    // recovery run from IDLE
    tb_delay = 5;
    tb_ct    = {$urandom, $urandom, $urandom, $urandom};
    press(1'b1, 1'b0, 1, 1'b0);
    wait_idle();
    press(1'b0, 1'b1, 0, 1'b0);

    repeat (5) tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
